// File: rtl/clock_unit.sv
// Fabric clock divider: three phase-aligned divided square waves plus a sticky
// o_valid that rises after a fixed number of post-reset cycles.

module clock_unit_div #(
  parameter int N = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_run,
  output logic o_clock
);
  localparam int W = (N > 2) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] HIGH = W'((N + 1) / 2);

  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_q, clk_d;

  // Until i_run is seen the counter holds at 0, so the first post-reset edge
  // loads cnt=0 / output high and every channel starts on the same edge.
  always_comb begin
    cnt_d = '0;
    if (i_run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
    clk_d = (cnt_d < HIGH);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign o_clock = clk_q;
endmodule

module clock_unit #(
  parameter int DIV0        = 2,
  parameter int DIV1        = 4,
  parameter int DIV2        = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_clock0,
  output logic o_clock1,
  output logic o_clock2,
  output logic o_valid
);
  if (DIV0 < 2 || DIV1 < 2 || DIV2 < 2 || LOCK_CYCLES < 1) begin : g_cfg_error
    $fatal(1, "clock_unit: DIV0/DIV1/DIV2 must be >= 2 and LOCK_CYCLES >= 1");
  end

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

  logic [LW-1:0] lock_q, lock_d;
  logic          valid_q, valid_d;
  logic          run;

  // A non-zero lock count means at least one non-reset edge has passed.
  assign run = (lock_q != '0);

  always_comb begin
    lock_d  = (lock_q == LOCK_MAX) ? lock_q : lock_q + LW'(1);
    valid_d = (lock_d == LOCK_MAX);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      lock_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      valid_q <= valid_d;
    end
  end

  clock_unit_div #(.N(DIV0)) u_div0 (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_run   (run),
    .o_clock (o_clock0)
  );

  clock_unit_div #(.N(DIV1)) u_div1 (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_run   (run),
    .o_clock (o_clock1)
  );

  clock_unit_div #(.N(DIV2)) u_div2 (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_run   (run),
    .o_clock (o_clock2)
  );

  assign o_valid = valid_q;
endmodule

// File: tb/tb_clock_unit.sv
// Bench for clock_unit: default configuration and a 3/5/2/1 configuration
// run side by side, checked every cycle against hand-written output tables.

module tb_clock_unit;
  logic clk;
  logic rst;

  logic a_clock0, a_clock1, a_clock2, a_valid;
  logic b_clock0, b_clock1, b_clock2, b_valid;

  int n_vec;
  int n_miss;
  int age;

  // Hand-computed waveforms, index = edges since reset release (mod period).
  int pa0[2] = '{1, 0};
  int pa1[4] = '{1, 1, 0, 0};
  int pa2[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  int pb0[3] = '{1, 1, 0};
  int pb1[5] = '{1, 1, 1, 0, 0};
  int pb2[2] = '{1, 0};

  clock_unit u_dut_a (
    .i_clock  (clk),
    .i_reset  (rst),
    .o_clock0 (a_clock0),
    .o_clock1 (a_clock1),
    .o_clock2 (a_clock2),
    .o_valid  (a_valid)
  );

  clock_unit #(.DIV0(3), .DIV1(5), .DIV2(2), .LOCK_CYCLES(1)) u_dut_b (
    .i_clock  (clk),
    .i_reset  (rst),
    .o_clock0 (b_clock0),
    .o_clock1 (b_clock1),
    .o_clock2 (b_clock2),
    .o_valid  (b_valid)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (age %0d, t=%0t)", tag, got, exp, age, $time);
    end
  endtask

  // Apply one edge with the given reset level, then compare both DUTs.
  task automatic cycle(input logic r);
    int k;
    rst = r;
    @(posedge clk);
    #1;
    if (r) age = 0;
    else age++;
    if (age == 0) begin
      check("a_clock0_rst", 32'(a_clock0), 0);
      check("a_clock1_rst", 32'(a_clock1), 0);
      check("a_clock2_rst", 32'(a_clock2), 0);
      check("a_valid_rst",  32'(a_valid),  0);
      check("b_clock0_rst", 32'(b_clock0), 0);
      check("b_clock1_rst", 32'(b_clock1), 0);
      check("b_clock2_rst", 32'(b_clock2), 0);
      check("b_valid_rst",  32'(b_valid),  0);
    end else begin
      k = age - 1;
      check("a_clock0", 32'(a_clock0), 32'(pa0[k % 2]));
      check("a_clock1", 32'(a_clock1), 32'(pa1[k % 4]));
      check("a_clock2", 32'(a_clock2), 32'(pa2[k % 8]));
      check("a_valid",  32'(a_valid),  (age >= 16) ? 32'd1 : 32'd0);
      check("b_clock0", 32'(b_clock0), 32'(pb0[k % 3]));
      check("b_clock1", 32'(b_clock1), 32'(pb1[k % 5]));
      check("b_clock2", 32'(b_clock2), 32'(pb2[k % 2]));
      check("b_valid",  32'(b_valid),  32'd1);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    age    = 0;
    rst    = 1'b1;

    // Reset held for 12 edges, then release and run through valid assertion.
    repeat (12) cycle(1'b1);
    repeat (40) cycle(1'b0);

    // o_valid must stay high for a long stretch.
    repeat (1000) cycle(1'b0);

    // Single-edge reset while o_valid=1 and o_clock2 is mid-high.
    while (((age - 1) % 8) != 1) cycle(1'b0);
    check("mid_valid_before", 32'(a_valid), 32'd1);
    check("mid_clock2_before", 32'(a_clock2), 32'd1);
    cycle(1'b1);
    repeat (40) cycle(1'b0);

    // Random reset pulses of 1..3 edges.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        repeat ($urandom_range(1, 3)) cycle(1'b1);
      end else begin
        cycle(1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
